spi_target: RTL

SPI mode-0 target (slave) that answers an external SPI controller on the four-pin interface (cs, sck, mosi, miso) and hands received bytes to, and takes transmit bytes from, the on-chip peripheral side. All SPI pins are oversampled in the system clock domain, so no logic runs on sck. It is the responder counterpart to the SPI controller pins of the system top and sits beside the other peripherals behind the peripheral bus glue.

---
 rtl/spi_target_if.sv | 19 +
 rtl/spi_target.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/spi_target_if.sv
// spi_target_if: peripheral-side transmit/receive byte streams of the SPI target.
interface spi_target_if #(parameter int N = 8);
  logic [N-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         overrun;
  logic         busy;
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, overrun, busy
  );
  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, overrun, busy
  );
endinterface

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target with all pins oversampled in the clk domain.
// Define SPI_TARGET_RX_FIFO_EN to replace the rx holding register by a 4-entry FIFO.
module spi_target #(
  parameter int           N    = 8,
  parameter logic [N-1:0] FILL = '1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         cs,
  input  logic         sck,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe,
  spi_target_if.slave  bus
);
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t       state_q, state_d;
  logic         cs_m_q, cs_s_q, sck_m_q, sck_s_q, sck_d_q, mosi_m_q, mosi_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  // the final bit comes straight from mosi_s, so only N-1 bits need storing
  logic [N-2:0] rx_shift_q, rx_shift_d;
  logic [N-1:0] tx_shift_q, tx_shift_d;
  logic [N-1:0] tx_buf_q, tx_buf_d;
  logic         tx_full_q, tx_full_d;
  logic         overrun_q, overrun_d;
  logic         sck_rise, sck_fall, done, load, tx_acc, pop;
  logic [N-1:0] rx_byte;
  assign sck_rise = sck_s_q & ~sck_d_q;
  assign sck_fall = ~sck_s_q & sck_d_q;
  assign rx_byte  = {rx_shift_q, mosi_s_q};
  assign tx_acc   = bus.tx_valid & ~tx_full_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    done       = 1'b0;
    load       = 1'b0;
    if (state_q == IDLE) begin
      if (!cs_s_q) begin
        state_d = ACTIVE;
        cnt_d   = '0;
        load    = 1'b1;
      end
    end else if (cs_s_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (sck_rise) begin
      rx_shift_d = rx_byte[N-2:0];
      done       = cnt_q == CW'(N-1);
      cnt_d      = done ? '0 : cnt_q + 1'b1;
    end else if (sck_fall) begin
      load       = cnt_q == '0;
      tx_shift_d = tx_shift_q << 1;
    end
    if (load) tx_shift_d = tx_full_q ? tx_buf_q : FILL;
    tx_full_d = tx_acc | (tx_full_q & ~load);
    tx_buf_d  = tx_acc ? bus.tx_data : tx_buf_q;
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cs_m_q     <= 1'b1;
      cs_s_q     <= 1'b1;
      sck_m_q    <= 1'b0;
      sck_s_q    <= 1'b0;
      sck_d_q    <= 1'b0;
      mosi_m_q   <= 1'b0;
      mosi_s_q   <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cs_m_q     <= cs;
      cs_s_q     <= cs_m_q;
      sck_m_q    <= sck;
      sck_s_q    <= sck_m_q;
      sck_d_q    <= sck_s_q;
      mosi_m_q   <= mosi;
      mosi_s_q   <= mosi_m_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      overrun_q  <= overrun_d;
    end
  end
`ifdef SPI_TARGET_RX_FIFO_EN
  logic [N-1:0] mem_q [4];
  logic [N-1:0] mem_d [4];
  logic [1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [2:0]   lvl_q, lvl_d;
  logic         push;
  assign pop  = (lvl_q != 3'd0) & bus.rx_ready;
  // a pop frees a slot in the same cycle, so a full FIFO still accepts
  assign push = done & ((lvl_q != 3'd4) | pop);
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = rx_byte;
    wp_d      = push ? wp_q + 2'd1 : wp_q;
    rp_d      = pop ? rp_q + 2'd1 : rp_q;
    lvl_d     = lvl_q + {2'b0, push} - {2'b0, pop};
    overrun_d = pop ? 1'b0 : overrun_q | (done & ~push);
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
    end
  end
  assign bus.rx_valid = lvl_q != 3'd0;
  assign bus.rx_data  = mem_q[rp_q];
`else
  logic [N-1:0] rx_data_q, rx_data_d;
  logic         rx_valid_q, rx_valid_d;
  assign pop = rx_valid_q & bus.rx_ready;
  // a read in the completion cycle makes room for the new byte
  always_comb begin
    rx_valid_d = done | (rx_valid_q & ~pop);
    rx_data_d  = (done & (~rx_valid_q | pop)) ? rx_byte : rx_data_q;
    overrun_d  = pop ? 1'b0 : overrun_q | (done & rx_valid_q);
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
`endif
  assign bus.overrun  = overrun_q;
  assign bus.tx_ready = ~tx_full_q;
  assign bus.busy     = state_q == ACTIVE;
  assign miso_oe      = state_q == ACTIVE;
  assign miso         = (state_q == ACTIVE) ? tx_shift_q[N-1] : 1'b1;
endmodule
